// File: rtl/as_uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive-side controller.
// Contents:
//   uart_width       - bits per received character
//   uart_frame_ticks - bit-period ticks per frame (start + 8 data + parity + stop)
//   baud_state_t     - baud sequencer state encoding
package as_uart_rx_ctrl_pkg;

  localparam int uart_width       = 8;
  localparam int uart_frame_ticks = 11;

  typedef enum logic {BAUD_IDLE, BAUD_RUN} baud_state_t;

endpackage

// File: rtl/as_uart_rx_ctrl_if.sv
// Bus-side register interface of the receive controller.
// Signals are named from the controller's point of view:
//   rd_i, flush_i, clr_ovr_i         - requests from the register file
//   rd_data_o, empty_o, full_o,
//   count_o, overrun_o, irq_o        - FIFO and interrupt status back to it
// modport master: register-file side; modport slave: controller side.
interface as_uart_rx_ctrl_if
  import as_uart_rx_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) ();

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  rd_i;
  logic                  flush_i;
  logic                  clr_ovr_i;
  logic [uart_width-1:0] rd_data_o;
  logic                  empty_o;
  logic                  full_o;
  logic [CNT_W-1:0]      count_o;
  logic                  overrun_o;
  logic                  irq_o;

  modport master (
    output rd_i, flush_i, clr_ovr_i,
    input  rd_data_o, empty_o, full_o, count_o, overrun_o, irq_o
  );

  modport slave (
    input  rd_i, flush_i, clr_ovr_i,
    output rd_data_o, empty_o, full_o, count_o, overrun_o, irq_o
  );

endinterface

// File: rtl/as_uart_fifo.sv
// Synchronous show-ahead FIFO for received characters.
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   push_i/wdata_i - write request and data (dropped when full unless a pop frees space)
//   pop_i          - advance head (ignored when empty)
//   flush_i        - empty the FIFO; overrides a simultaneous push/pop
//   rdata_o        - head entry, zero when empty
//   count_o, full_o, empty_o - occupancy status, all from registered state
module as_uart_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             pop_s;
  logic             push_s;

  // Occupancy and pointer next-state; a pop in the same cycle makes room for a push into a full FIFO.
  always_comb begin
    pop_s    = pop_i & ~empty_q;
    push_s   = push_i & (~full_q | pop_s);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    empty_d = (count_d == {CW{1'b0}});
    full_d  = (count_d == CW'(DEPTH));
  end

  // Pointer, count and status flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = empty_q ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/as_uart_rx_ctrl.sv
// Receive-side controller for the UART receiver.
// Ports:
//   clk_i, rst_i     - clock, synchronous active-high reset
//   cfg_en_i         - receiver enable
//   cfg_div_i        - clocks per bit (>= 4, stable during a frame)
//   cfg_irq_en_i     - interrupt enable
//   rx_start_i       - start-bit pulse from the receiver
//   rx_rdy_i         - byte-complete pulse; rx_data_i is valid the cycle after
//   rx_data_i        - received byte
//   br_o, br2_o      - bit-period and mid-bit ticks to the receiver
//   bus              - register-file interface (FIFO read, flush, status, irq)
module as_uart_rx_ctrl
  import as_uart_rx_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_en_i,
  input  logic [DIV_WIDTH-1:0]  cfg_div_i,
  input  logic                  cfg_irq_en_i,
  input  logic                  rx_start_i,
  input  logic                  rx_rdy_i,
  input  logic [uart_width-1:0] rx_data_i,
  output logic                  br_o,
  output logic                  br2_o,
  as_uart_rx_ctrl_if.slave      bus
);

  localparam int TW = $clog2(uart_frame_ticks + 1);

  baud_state_t          state_q, state_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [DIV_WIDTH-1:0] div_last_s;
  logic [DIV_WIDTH-1:0] div_half_s;
  logic                 br_q, br_d;
  logic                 br2_q, br2_d;
  logic                 rdy_q;
  logic                 ovr_q, ovr_d;
  logic                 irq_q, irq_d;
  logic                 drop_s;

  assign div_last_s = cfg_div_i - DIV_WIDTH'(1);
  assign div_half_s = (cfg_div_i >> 1) - DIV_WIDTH'(1);

  // Baud sequencer next state; ticks are decoded from the next state so they leave as registered pulses.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    tick_cnt_d = tick_cnt_q;
    case (state_q)
      BAUD_IDLE: begin
        if (rx_start_i && cfg_en_i) begin
          state_d    = BAUD_RUN;
          div_cnt_d  = {DIV_WIDTH{1'b0}};
          tick_cnt_d = {TW{1'b0}};
        end else begin
          state_d = BAUD_IDLE;
        end
      end
      BAUD_RUN: begin
        if (!cfg_en_i) begin
          state_d = BAUD_IDLE;
        end else if (div_cnt_q == div_last_s) begin
          div_cnt_d  = {DIV_WIDTH{1'b0}};
          tick_cnt_d = tick_cnt_q + TW'(1);
          // This br is the last of the frame: idle from the next cycle on.
          if (tick_cnt_q == TW'(uart_frame_ticks - 1)) begin
            state_d = BAUD_IDLE;
          end else begin
            state_d = BAUD_RUN;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
      end
      default: begin
        state_d = BAUD_IDLE;
      end
    endcase
    br_d  = (state_d == BAUD_RUN) && (div_cnt_d == div_last_s);
    br2_d = (state_d == BAUD_RUN) && (div_cnt_d == div_half_s);
  end

  // Baud sequencer state and tick registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BAUD_IDLE;
      div_cnt_q  <= {DIV_WIDTH{1'b0}};
      tick_cnt_q <= {TW{1'b0}};
      br_q       <= 1'b0;
      br2_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      br_q       <= br_d;
      br2_q      <= br2_d;
    end
  end

  // A push into a full FIFO is lost unless a read frees the slot in the same cycle.
  assign drop_s = rdy_q & bus.full_o & ~bus.rd_i;

  // Overrun flag and interrupt next state; flush beats a new overrun, a new overrun beats clear.
  always_comb begin
    ovr_d = ovr_q;
    if (bus.flush_i) begin
      ovr_d = 1'b0;
    end else if (drop_s) begin
      ovr_d = 1'b1;
    end else if (bus.clr_ovr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    irq_d = cfg_irq_en_i & (~bus.empty_o | ovr_q);
  end

  // Delayed byte-ready strobe, overrun flag and interrupt registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdy_q <= 1'b0;
      ovr_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      // The receiver's data settles one cycle after its ready pulse.
      rdy_q <= rx_rdy_i & cfg_en_i;
      ovr_q <= ovr_d;
      irq_q <= irq_d;
    end
  end

  as_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (uart_width)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rdy_q),
    .wdata_i (rx_data_i),
    .pop_i   (bus.rd_i),
    .flush_i (bus.flush_i),
    .rdata_o (bus.rd_data_o),
    .count_o (bus.count_o),
    .full_o  (bus.full_o),
    .empty_o (bus.empty_o)
  );

  assign br_o          = br_q;
  assign br2_o         = br2_q;
  assign bus.overrun_o = ovr_q;
  assign bus.irq_o     = irq_q;

endmodule
